alu: RTL and testbench
======================

Name: alu

Overview:
- 64-bit integer ALU for the single-cycle processor datapath, placed between the register-file/immediate mux and the writeback/branch logic.
- The result and condition outputs are purely combinational from a, b and ALUControl.
- An optional NZCV flag register, clocked by the processor clock, captures the condition outputs for later conditional branches.

Parameters:
- WIDTH, 64, operand and result width in bits. Must be ≥ 8. Shift amounts use the low $clog2(WIDTH) bits of b.

Ports:
- clk  input  1  processor clock; used only by the flag register.
- reset  input  1  synchronous, active-high reset; used only by the flag register.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ALUControl  input  4  operation select.
- flag_we  input  1  when high, the flag register loads {negative, zero, carry, overflow} at the clk rising edge.
- result  output  WIDTH  operation result (combinational).
- zero  output  1  high when result == 0 (combinational).
- negative  output  1  result[WIDTH-1] (combinational).
- carry  output  1  carry/no-borrow (combinational).
- overflow  output  1  signed overflow (combinational).
- flags_q  output  4  registered {N, Z, C, V}.

Behaviour:
- ALUControl encoding:
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: a + b, modulo 2^WIDTH.
  - 0011 XOR: a ^ b.
  - 0100 LSL: a << b[s-1:0].
  - 0101 LSR: logical a >> b[s-1:0].
  - 0110 SUB: a - b, modulo 2^WIDTH.
  - 0111 PASSB: b.
  - 1000 ASR: arithmetic a >>> b[s-1:0].
  - 1001 SLT: 1 if signed a < signed b, else 0 (zero-extended).
  - 1010 SLTU: 1 if unsigned a < b, else 0.
  - 1100 NOR: ~(a | b).
  - All other codes: result = 0.
- s = $clog2(WIDTH).
- Combinational path:
  - result, zero, negative, carry and overflow settle with no clock involvement.
  - None of these outputs depend on clk or reset.
- ADD:
  - carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - overflow = (a[msb] == b[msb]) && (result[msb] != a[msb]).
  - Example: -1 + 1 gives result 0, zero 1, carry 1, overflow 0.
- SUB:
  - Computed as a + ~b + 1.
  - carry = 1 when no borrow (unsigned a ≥ b).
  - overflow = (a[msb] != b[msb]) && (result[msb] != a[msb]).
- All other operations: carry = 0, overflow = 0.
- zero = (result == 0) for every operation, including the undefined codes (result 0, so zero = 1).
- negative = result[WIDTH-1] for every operation.
- SLT uses the true signed comparison, correct even when a - b overflows.
- Flag register:
  - On the clk rising edge: if reset, flags_q ← 0000; else if flag_we, flags_q ← {negative, zero, carry, overflow}; else hold.
  - Reset has priority over flag_we when both are asserted.
  - flags_q reads 0000 from reset until the first enabled write.
  - Latency: flags_q reflects the operation present one cycle before.

Optional Feature:
- Macro: ALU_FLAG_REG_EN.
- Defined: the flag register is implemented as specified above.
- Not defined: flags_q is tied to 4'b0000 and clk, reset and flag_we are ignored; all combinational outputs are unchanged.

Test Plan:
- AND / OR with a=10, b=7:
  - AND → 0x2; OR → 0xF.
  - AND with a=-10, b=-2 → 0xFFFF_FFFF_FFFF_FFF6.
  - OR with a=7, b=-2 → all ones.
- ADD:
  - 10+7 → 17 (0x11).
  - -10+(-2) → -12, negative 1, carry 1.
  - 7+(-2) → 5.
  - 10+(-10) → 0, zero 1.
  - all-ones+1 → 0, zero 1, carry 1, overflow 0.
  - 0x7FFF…F+1 → overflow 1, negative 1.
- SUB:
  - 10-7 → 3, carry 1.
  - -10-(-2) → -8 (0x…FFF8).
  - 7-(-2) → 9.
  - 0-1 → all ones, carry 0.
- PASSB: a=0xF, b=0x5 → 0x5.
- Other operations:
  - LSL 1 by 63 → 0x8000…0.
  - ASR 0x8000…0 by 63 → all ones.
  - SLT with a=-1, b=1 → 1; SLTU with the same operands → 0.
  - ALUControl=1111 → 0, zero 1.
- Flag register (ALU_FLAG_REG_EN defined):
  - Reset → flags_q 0000.
  - SUB 5-5 with flag_we=1 → next edge flags_q=0110.
  - flag_we=0 → flags_q held.
  - reset and flag_we asserted together → 0000.

Source files
------------

// File: rtl/alu.sv
// 64-bit datapath ALU: combinational result and NZCV condition outputs.
// Optional registered NZCV copy when ALU_FLAG_REG_EN is defined.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  input  logic             flag_we,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic [3:0]       flags_q
);

  localparam int S = $clog2(WIDTH);
  localparam int M = WIDTH - 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_LSL   = 4'b0100;
  localparam logic [3:0] OP_LSR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_ASR   = 4'b1000;
  localparam logic [3:0] OP_SLT   = 4'b1001;
  localparam logic [3:0] OP_SLTU  = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  logic [S-1:0] shamt;
  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] sub_sum;
  logic slt;
  logic sltu;

  assign shamt = b[S-1:0];

  // Wide sums expose the carry-out; subtract is a + ~b + 1 so carry means no borrow.
  always_comb begin
    add_sum = {1'b0, a} + {1'b0, b};
    sub_sum = {1'b0, a} + {1'b0, ~b}
            + {{WIDTH{1'b0}}, 1'b1};
    slt     = $signed(a) < $signed(b);
    sltu    = a < b;
  end

  // Operation select; carry and overflow only meaningful for add/sub.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (ALUControl)
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_ADD: begin
        result   = add_sum[M:0];
        carry    = add_sum[WIDTH];
        overflow = (a[M] == b[M])
                && (add_sum[M] != a[M]);
      end
      OP_XOR:   result = a ^ b;
      OP_LSL:   result = a << shamt;
      OP_LSR:   result = a >> shamt;
      OP_SUB: begin
        result   = sub_sum[M:0];
        carry    = sub_sum[WIDTH];
        overflow = (a[M] != b[M])
                && (sub_sum[M] != a[M]);
      end
      OP_PASSB: result = b;
      OP_ASR:   result = WIDTH'($signed(a) >>> shamt);
      OP_SLT:   result = {{(WIDTH-1){1'b0}}, slt};
      OP_SLTU:  result = {{(WIDTH-1){1'b0}}, sltu};
      OP_NOR:   result = ~(a | b);
      default:  result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[M];

`ifdef ALU_FLAG_REG_EN
  // NZCV capture for later conditional branches; reset wins over write.
  always_ff @(posedge clk) begin
    if (reset)
      flags_q <= 4'b0000;
    else if (flag_we)
      flags_q <= {negative, zero, carry, overflow};
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = &{1'b0, clk, reset, flag_we};
  assign flags_q = 4'b0000;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu with hand-computed expectations.
// Flag register checks adapt to whether ALU_FLAG_REG_EN is defined.
module tb_alu;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   ALUControl;
  logic         flag_we;
  logic [W-1:0] result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;
  logic [3:0]   flags_q;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};

  alu #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .a(a),
    .b(b),
    .ALUControl(ALUControl),
    .flag_we(flag_we),
    .result(result),
    .zero(zero),
    .negative(negative),
    .carry(carry),
    .overflow(overflow),
    .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] op,
                       input logic [W-1:0] va,
                       input logic [W-1:0] vb);
    @(negedge clk);
    ALUControl = op;
    a = va;
    b = vb;
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks {N,Z,C,V} combinational condition outputs together.
  task automatic chkf(input string tag, input logic [3:0] exp);
    chk(tag, {60'd0, negative, zero, carry, overflow},
        {60'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    flag_we = 1'b0;
    a = '0;
    b = '0;
    ALUControl = 4'b0000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_flags", {60'd0, flags_q}, 64'd0);

    drive(4'b0000, 64'd10, 64'd7);
    chk("and_10_7", result, 64'h2);
    drive(4'b0001, 64'd10, 64'd7);
    chk("or_10_7", result, 64'hF);
    chkf("or_flags", 4'b0000);
    drive(4'b0000, -64'sd10, -64'sd2);
    chk("and_neg", result, 64'hFFFF_FFFF_FFFF_FFF6);
    drive(4'b0001, 64'd7, -64'sd2);
    chk("or_ones", result, ONES);

    drive(4'b0010, 64'd10, 64'd7);
    chk("add_10_7", result, 64'h11);
    chkf("add_10_7_f", 4'b0000);
    drive(4'b0010, -64'sd10, -64'sd2);
    chk("add_neg", result, 64'hFFFF_FFFF_FFFF_FFF4);
    chkf("add_neg_f", 4'b1010);
    drive(4'b0010, 64'd7, -64'sd2);
    chk("add_7_m2", result, 64'd5);
    drive(4'b0010, 64'd10, -64'sd10);
    chk("add_zero", result, 64'd0);
    chkf("add_zero_f", 4'b0110);
    drive(4'b0010, ONES, 64'd1);
    chk("add_wrap", result, 64'd0);
    chkf("add_wrap_f", 4'b0110);
    drive(4'b0010, MAXP, 64'd1);
    chk("add_ovf", result, MSB);
    chkf("add_ovf_f", 4'b1001);

    drive(4'b0110, 64'd10, 64'd7);
    chk("sub_10_7", result, 64'd3);
    chkf("sub_10_7_f", 4'b0010);
    drive(4'b0110, -64'sd10, -64'sd2);
    chk("sub_neg", result, 64'hFFFF_FFFF_FFFF_FFF8);
    chkf("sub_neg_f", 4'b1000);
    drive(4'b0110, 64'd7, -64'sd2);
    chk("sub_7_m2", result, 64'd9);
    chkf("sub_7_m2_f", 4'b0000);
    drive(4'b0110, 64'd0, 64'd1);
    chk("sub_borrow", result, ONES);
    chkf("sub_borrow_f", 4'b1000);
    drive(4'b0110, MSB, 64'd1);
    chk("sub_ovf", result, MAXP);
    chkf("sub_ovf_f", 4'b0011);

    drive(4'b0111, 64'hF, 64'h5);
    chk("passb", result, 64'h5);
    drive(4'b0011, 64'hF0F0, 64'hFF00);
    chk("xor", result, 64'h0FF0);
    drive(4'b1100, 64'hF0, 64'h0F);
    chk("nor", result, 64'hFFFF_FFFF_FFFF_FF00);
    drive(4'b0100, 64'd1, 64'd63);
    chk("lsl_63", result, MSB);
    drive(4'b0100, 64'h3, 64'h104);
    chk("lsl_lowbits", result, 64'h30);
    drive(4'b0101, MSB, 64'd63);
    chk("lsr_63", result, 64'd1);
    drive(4'b1000, MSB, 64'd63);
    chk("asr_63", result, ONES);
    chkf("asr_63_f", 4'b1000);
    drive(4'b1000, 64'h7000_0000_0000_0000, 64'd4);
    chk("asr_pos", result, 64'h0700_0000_0000_0000);
    drive(4'b1001, ONES, 64'd1);
    chk("slt_m1_1", result, 64'd1);
    drive(4'b1010, ONES, 64'd1);
    chk("sltu_m1_1", result, 64'd0);
    drive(4'b1001, MSB, 64'd1);
    chk("slt_ovf", result, 64'd1);
    drive(4'b1001, MAXP, ONES);
    chk("slt_ovf2", result, 64'd0);
    drive(4'b1010, 64'd3, 64'd9);
    chk("sltu_3_9", result, 64'd1);
    drive(4'b1111, ONES, ONES);
    chk("undef_1111", result, 64'd0);
    chkf("undef_f", 4'b0100);
    drive(4'b1011, ONES, 64'd1);
    chk("undef_1011", result, 64'd0);

`ifdef ALU_FLAG_REG_EN
    drive(4'b0110, 64'd5, 64'd5);
    flag_we = 1'b1;
    @(posedge clk);
    #1;
    chk("freg_sub55", {60'd0, flags_q}, 64'h6);
    flag_we = 1'b0;
    drive(4'b0010, MAXP, 64'd1);
    @(posedge clk);
    #1;
    chk("freg_hold", {60'd0, flags_q}, 64'h6);
    flag_we = 1'b1;
    @(posedge clk);
    #1;
    chk("freg_load2", {60'd0, flags_q}, 64'h9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("freg_rst_pri", {60'd0, flags_q}, 64'h0);
    reset = 1'b0;
    flag_we = 1'b0;
`else
    drive(4'b0110, 64'd5, 64'd5);
    flag_we = 1'b1;
    @(posedge clk);
    #1;
    chk("freg_tied", {60'd0, flags_q}, 64'h0);
    flag_we = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
